// File: rtl/div_pkg.sv
// Shared types and constants for the sequential MIPS divider.
// Holds the FSM state enum and the iteration count/width constants.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH;
    localparam int DIV_CNT_W  = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports: rem_i/quo_i/divisor_i in; rem_o/quo_o out (next partial state).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // rem_i < divisor_i always holds, so the shifted partial remainder is
    // below 2*divisor and a WIDTH+1 bit difference carries a valid sign.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        fits    = ~trial[WIDTH];
        rem_o   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; LO=QUOTIENT, HI=REMAINDER.
// Ports: clk, resetn, START/SIGNED/CANCEL, DIVIDEND/DIVISOR in;
// READY (idle), VALID (1-cycle result pulse), QUOTIENT/REMAINDER out.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             START,
    input  logic             SIGNED,
    input  logic             CANCEL,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             READY,
    output logic             VALID,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             valid_q, valid_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign a_neg = SIGNED & DIVIDEND[WIDTH-1];
    assign b_neg = SIGNED & DIVISOR[WIDTH-1];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvsr_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        valid_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START && !CANCEL) begin
                    // quo doubles as the dividend shift register
                    quo_d     = a_neg ? -DIVIDEND : DIVIDEND;
                    dvsr_d    = b_neg ? -DIVISOR : DIVISOR;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (DIVISOR == '0) begin
                        state_d     = DONE;
                        valid_d     = 1'b1;
                        quotient_d  = '1;
                        remainder_d = DIVIDEND;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    valid_d     = 1'b1;
                    quotient_d  = neg_quo_q ? -step_quo : step_quo;
                    remainder_d = neg_rem_q ? -step_rem : step_rem;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush wins over everything and leaves the last result intact.
        if (CANCEL) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
        end
    end

    assign READY     = (state_q == IDLE);
    assign VALID     = valid_q & ~CANCEL;
    assign QUOTIENT  = quotient_q;
    assign REMAINDER = remainder_q;

endmodule
